rle_block_decoder: RTL and testbench

RLE_BLOCK_DECODER -- requirements
Module: rle_block_decoder

---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/zigzag_lut.sv | 11 +
 rtl/rle_block_decoder.sv | 127 ++++++++++++
 tb/tb_rle_block_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: coefficient/run widths, block size, decoder states
// and the zigzag-to-raster table used by both encoder and decoder sides.
package jpeg_pkg;

  localparam int COEF_W     = 8;
  localparam int RUN_W      = 6;
  localparam int BLOCK_SIZE = 64;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } dec_state_t;

  // Entry k holds the raster address (row*8 + col) of zigzag position k.
  localparam logic [5:0] ZZ_TO_RASTER [BLOCK_SIZE] = '{
     6'd0,  6'd1,  6'd8, 6'd16,  6'd9,  6'd2,  6'd3, 6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11,  6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13,  6'd6,  6'd7, 6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_lut.sv
// Combinational zigzag-index to raster-index lookup.
module zigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_idx
);

  assign raster_idx = ZZ_TO_RASTER[zz_idx];

endmodule

// File: rtl/rle_block_decoder.sv
// Run-length decoder: accepts {run, level} symbols in zigzag order, builds an
// 8x8 coefficient block in raster order, then streams it out one row per
// accepted handshake.
module rle_block_decoder #(
  parameter int COEF_W = jpeg_pkg::COEF_W,
  parameter int RUN_W  = jpeg_pkg::RUN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [RUN_W+COEF_W-1:0] sym_in,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic [8*COEF_W-1:0]     row_out,
  output logic [2:0]              row_idx,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic                    block_done,
  output logic                    err
);

  import jpeg_pkg::*;

  // Wide enough to hold pos (max 63) plus the largest run without wrapping.
  localparam int SUM_W = ((RUN_W > 7) ? RUN_W : 7) + 1;

  dec_state_t        state;
  dec_state_t        state_next;
  logic [COEF_W-1:0] coef_buf [BLOCK_SIZE];
  logic [6:0]        pos;
  logic [2:0]        row_cnt;
  logic              err_q;

  logic [RUN_W-1:0]  run;
  logic [COEF_W-1:0] level;
  logic [SUM_W-1:0]  target;
  logic [SUM_W-1:0]  pos_after;
  logic [5:0]        raster_addr;
  logic              sym_fire;
  logic              row_fire;
  logic              is_eob;
  logic              overflow;
  logic              last_pos;
  logic              last_row;

  assign run       = sym_in[RUN_W+COEF_W-1:COEF_W];
  assign level     = sym_in[COEF_W-1:0];
  assign target    = SUM_W'(pos) + SUM_W'(run);
  assign pos_after = target + SUM_W'(1);
  assign is_eob    = (run == '0) && (level == '0);
  assign overflow  = target > SUM_W'(BLOCK_SIZE - 1);
  assign last_pos  = pos_after == SUM_W'(BLOCK_SIZE);
  assign sym_fire  = sym_valid && sym_ready;
  assign row_fire  = row_valid && row_ready;
  assign last_row  = row_cnt == 3'd7;
  assign err       = err_q;

  zigzag_lut u_zigzag_lut (
    .zz_idx     (target[5:0]),
    .raster_idx (raster_addr)
  );

  // Handshake and row outputs; everything is forced low while reset is high.
  always_comb begin
    sym_ready  = 1'b0;
    row_valid  = 1'b0;
    block_done = 1'b0;
    row_idx    = '0;
    row_out    = '0;
    if (!reset) begin
      if (state == FILL) begin
        sym_ready = 1'b1;
      end else begin
        row_valid  = 1'b1;
        row_idx    = row_cnt;
        block_done = row_ready && last_row;
        for (int c = 0; c < 8; c++) begin
          row_out[c*COEF_W +: COEF_W] = coef_buf[{row_cnt, c[2:0]}];
        end
      end
    end
  end

  // Next state: a block ends on EOB, on overflow, or when the last slot fills.
  always_comb begin
    state_next = state;
    case (state)
      FILL: if (sym_fire && (is_eob || overflow || last_pos)) state_next = EMIT;
      EMIT: if (row_fire && last_row) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_next;
  end

  // Coefficient buffer, zigzag pointer, row counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BLOCK_SIZE; i++) coef_buf[i] <= '0;
      pos     <= '0;
      row_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (sym_fire && !is_eob) begin
        if (overflow) begin
          err_q <= 1'b1;
        end else begin
          coef_buf[raster_addr] <= level;
          pos                   <= pos_after[6:0];
        end
      end
      if (row_fire) begin
        if (last_row) begin
          for (int i = 0; i < BLOCK_SIZE; i++) coef_buf[i] <= '0;
          pos     <= '0;
          row_cnt <= '0;
        end else begin
          row_cnt <= row_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_block_decoder.sv
// Self-checking bench for rle_block_decoder: directed and random blocks
// compared against a queue/array reference model of the RLE + zigzag rules.
module tb_rle_block_decoder;

  logic        clk;
  logic        reset;
  logic [13:0] sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic [63:0] row_out;
  logic [2:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic        block_done;
  logic        err;

  int          n_asserts;
  int          n_fails;
  int          zz_tab [64];
  logic [7:0]  exp_buf [64];
  logic        err_exp;

  rle_block_decoder #(.COEF_W(8), .RUN_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .row_out    (row_out),
    .row_idx    (row_idx),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .block_done (block_done),
    .err        (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Zigzag order derived by walking the anti-diagonals of the 8x8 block.
  task automatic build_zigzag();
    int idx;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_tab[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_tab[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end
  endtask

  // Reference model: decode a symbol list into exp_buf; returns symbols consumed.
  task automatic model_block(input logic [13:0] syms [$], output bit ovf, output int used);
    int pos;
    int run;
    logic [7:0] lvl;
    pos  = 0;
    ovf  = 1'b0;
    used = 0;
    for (int i = 0; i < 64; i++) exp_buf[i] = 8'd0;
    foreach (syms[i]) begin
      run = int'(syms[i][13:8]);
      lvl = syms[i][7:0];
      used++;
      if (run == 0 && lvl == 8'd0) return;
      if (pos + run > 63) begin
        ovf = 1'b1;
        return;
      end
      exp_buf[zz_tab[pos + run]] = lvl;
      pos = pos + run + 1;
      if (pos == 64) return;
    end
  endtask

  function automatic logic [63:0] exp_row(int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = exp_buf[r*8 + c];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Feed the symbols of one block with random idle gaps; row_valid must rise
  // exactly one cycle after the final symbol is accepted.
  task automatic applyStimulus(input logic [13:0] syms [$]);
    for (int i = 0; i < syms.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sym_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      sym_in    = syms[i];
      sym_valid = 1'b1;
      #1;
      checkOutput("sym_ready_fill", 64'(sym_ready), 64'(1'b1));
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
      checkOutput($sformatf("row_valid_after_sym%0d", i), 64'(row_valid),
                  64'(i == syms.size() - 1));
    end
  endtask

  // Drain nrows rows, optionally with a random row_ready, checking every cycle.
  task automatic collectRows(input int nrows, input bit rand_ready);
    int r;
    int budget;
    r = 0;
    budget = 0;
    while (r < nrows && budget < 400) begin
      row_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput("emit_row_valid", 64'(row_valid), 64'(1'b1));
      checkOutput("emit_sym_ready", 64'(sym_ready), 64'(1'b0));
      checkOutput($sformatf("row%0d_idx", r), 64'(row_idx), 64'(r));
      checkOutput($sformatf("row%0d_out", r), row_out, exp_row(r));
      checkOutput($sformatf("block_done_row%0d", r), 64'(block_done),
                  64'(row_ready && r == 7));
      if (row_ready) r++;
      budget++;
      @(posedge clk);
      #1;
    end
    row_ready = 1'b0;
    checkOutput("rows_delivered_in_budget", 64'(r), 64'(nrows));
    if (nrows == 8) begin
      checkOutput("post_block_row_valid", 64'(row_valid), 64'(1'b0));
      checkOutput("post_block_sym_ready", 64'(sym_ready), 64'(1'b1));
      checkOutput("post_block_done", 64'(block_done), 64'(1'b0));
    end
  endtask

  task automatic run_block(input logic [13:0] syms [$], input bit rand_ready);
    bit ovf;
    int used;
    model_block(syms, ovf, used);
    if (ovf) err_exp = 1'b1;
    applyStimulus(syms);
    collectRows(8, rand_ready);
    checkOutput("err_flag", 64'(err), 64'(err_exp));
  endtask

  initial begin
    logic [13:0] q [$];
    bit ovf;
    int used;

    clk       = 1'b0;
    reset     = 1'b1;
    sym_in    = '0;
    sym_valid = 1'b0;
    row_ready = 1'b0;
    err_exp   = 1'b0;
    n_asserts = 0;
    n_fails   = 0;
    build_zigzag();

    $display("[TB] reset behaviour");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_row_valid", 64'(row_valid), 64'(1'b0));
    checkOutput("rst_sym_ready", 64'(sym_ready), 64'(1'b0));
    checkOutput("rst_row_out", row_out, 64'd0);
    checkOutput("rst_row_idx", 64'(row_idx), 64'd0);
    checkOutput("rst_block_done", 64'(block_done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_sym_ready", 64'(sym_ready), 64'(1'b1));

    $display("[TB] short block ending in EOB");
    q = '{{6'd0, 8'd20}, {6'd0, 8'hFD}, 14'd0};
    run_block(q, 1'b0);

    $display("[TB] run skips to zigzag position 2");
    q = '{{6'd2, 8'd5}, 14'd0};
    run_block(q, 1'b0);

    $display("[TB] full block without EOB");
    q.delete();
    for (int k = 1; k <= 64; k++) q.push_back({6'd0, 8'(k)});
    run_block(q, 1'b0);

    $display("[TB] run overflow then a normal block");
    q = '{{6'd0, 8'd1}, {6'd63, 8'd9}};
    run_block(q, 1'b0);
    q = '{{6'd0, 8'd11}, {6'd4, 8'd0}, {6'd1, 8'h80}, 14'd0};
    run_block(q, 1'b1);

    $display("[TB] random blocks with random backpressure");
    for (int b = 0; b < 8; b++) begin
      q.delete();
      for (int i = 0; i < 70; i++) begin
        logic [5:0] rn;
        rn = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
        q.push_back({rn, 8'($urandom)});
      end
      model_block(q, ovf, used);
      q = q[0:used-1];
      run_block(q, 1'b1);
    end

    $display("[TB] reset in the middle of row emission");
    q = '{{6'd0, 8'd3}, {6'd1, 8'hFE}, 14'd0};
    model_block(q, ovf, used);
    applyStimulus(q);
    collectRows(4, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_row_valid", 64'(row_valid), 64'(1'b0));
    checkOutput("midrst_row_out", row_out, 64'd0);
    checkOutput("midrst_sym_ready", 64'(sym_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    reset   = 1'b0;
    err_exp = 1'b0;
    #1;
    checkOutput("midrst_after_sym_ready", 64'(sym_ready), 64'(1'b1));
    checkOutput("midrst_after_row_valid", 64'(row_valid), 64'(1'b0));
    checkOutput("midrst_after_err", 64'(err), 64'(1'b0));
    q = '{{6'd0, 8'd7}, 14'd0};
    run_block(q, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
